// File: rtl/clk_div_prog.sv
// Programmable multi-channel clock divider: per-channel high/low phase lengths,
// staged config writes applied at period boundaries, and a global phase-align sync.
module clk_div_prog #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int CH_W     = 1,
  parameter int DEF_HIGH = 3,
  parameter int DEF_LOW  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_low,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic [NUM_CH-1:0] cfg_pending
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_HIGH = (DEF_HIGH < 1) ? ONE : CNT_W'(DEF_HIGH);
  localparam logic [CNT_W-1:0] RST_LOW  = (DEF_LOW < 1) ? ONE : CNT_W'(DEF_LOW);
  localparam logic [0:0]       PH_LOW   = 1'b0;
  localparam logic [0:0]       PH_HIGH  = 1'b1;

  // A zero length is stored as one so every phase lasts at least a cycle.
  logic [CNT_W-1:0] wr_high;
  logic [CNT_W-1:0] wr_low;
  assign wr_high = (cfg_high == '0) ? ONE : cfg_high;
  assign wr_low  = (cfg_low == '0) ? ONE : cfg_low;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [0:0]       phase;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_high;
    logic [CNT_W-1:0] act_low;
    logic [CNT_W-1:0] pend_high;
    logic [CNT_W-1:0] pend_low;
    logic             pending;
    logic             rise_q;
    logic             fall_q;
    logic             wr_hit;
    logic             at_end;
    logic             apply;

    // Out-of-range channel numbers never match any generated index.
    assign wr_hit = cfg_wr && (cfg_ch == CH_W'(g));
    assign at_end = (phase == PH_HIGH) ? (cnt >= act_high - ONE)
                                       : (cnt >= act_low - ONE);
    // Pending values land whenever the channel restarts a period from scratch.
    assign apply  = !en[g] || sync || ((phase == PH_HIGH) && at_end);

    always_ff @(posedge clk) begin
      if (!reset) begin
        phase     <= PH_LOW;
        cnt       <= '0;
        act_high  <= RST_HIGH;
        act_low   <= RST_LOW;
        pend_high <= RST_HIGH;
        pend_low  <= RST_LOW;
        pending   <= 1'b0;
        rise_q    <= 1'b0;
        fall_q    <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (!en[g]) begin
          phase <= PH_LOW;
          cnt   <= '0;
        end else if (sync) begin
          fall_q <= (phase == PH_HIGH);
          phase  <= PH_LOW;
          cnt    <= '0;
        end else if (at_end) begin
          cnt <= '0;
          if (phase == PH_LOW) begin
            phase  <= PH_HIGH;
            rise_q <= 1'b1;
          end else begin
            phase  <= PH_LOW;
            fall_q <= 1'b1;
          end
        end else begin
          cnt <= cnt + ONE;
        end

        if (apply && pending) begin
          act_high <= pend_high;
          act_low  <= pend_low;
        end

        // A write coinciding with an apply is staged for the next one.
        if (wr_hit) begin
          pend_high <= wr_high;
          pend_low  <= wr_low;
          pending   <= 1'b1;
        end else if (apply) begin
          pending <= 1'b0;
        end
      end
    end

    assign clk_out[g]     = phase;
    assign rise_pulse[g]  = rise_q;
    assign fall_pulse[g]  = fall_q;
    assign cfg_pending[g] = pending;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: hand-derived vector table, directed corner sequences,
// and random traffic checked against a period-position reference model.
module tb_clk_div_prog;

  localparam int NCH = 3;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] en;
  logic           sync;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_high;
  logic [7:0]     cfg_low;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;
  logic [NCH-1:0] cfg_pending;

  int checks = 0;
  int errors = 0;

  clk_div_prog #(.NUM_CH(NCH), .CNT_W(8), .CH_W(2), .DEF_HIGH(3), .DEF_LOW(3)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync), .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .clk_out(clk_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .cfg_pending(cfg_pending)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each channel tracks its position within the current period: output is high
  // once position reaches the low length, the period ends at low+high.
  int             m_pos[NCH];
  int             m_hi[NCH];
  int             m_lo[NCH];
  int             m_phi[NCH];
  int             m_plo[NCH];
  bit             m_pf[NCH];
  logic [NCH-1:0] m_out;
  logic [NCH-1:0] m_rise;
  logic [NCH-1:0] m_fall;
  logic [NCH-1:0] m_pend;

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      bit apply;
      bit was_high;
      apply    = 1'b0;
      was_high = (m_pos[i] >= m_lo[i]);
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (!reset) begin
        m_pos[i] = 0; m_hi[i] = 3; m_lo[i] = 3;
        m_phi[i] = 3; m_plo[i] = 3; m_pf[i] = 1'b0;
      end else begin
        if (!en[i]) begin
          m_pos[i] = 0;
          apply = 1'b1;
        end else if (sync) begin
          m_fall[i] = was_high;
          m_pos[i] = 0;
          apply = 1'b1;
        end else begin
          m_pos[i]++;
          if (m_pos[i] == m_lo[i]) m_rise[i] = 1'b1;
          if (m_pos[i] == m_lo[i] + m_hi[i]) begin
            m_pos[i] = 0;
            m_fall[i] = 1'b1;
            apply = 1'b1;
          end
        end
        if (apply && m_pf[i]) begin
          m_hi[i] = m_phi[i];
          m_lo[i] = m_plo[i];
          m_pf[i] = 1'b0;
        end
        if (cfg_wr && (int'(cfg_ch) == i)) begin
          m_phi[i] = (cfg_high == 8'd0) ? 1 : int'(cfg_high);
          m_plo[i] = (cfg_low == 8'd0) ? 1 : int'(cfg_low);
          m_pf[i]  = 1'b1;
        end
      end
      m_out[i]  = (m_pos[i] >= m_lo[i]);
      m_pend[i] = m_pf[i];
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: advance the model with the current inputs, then compare all outputs.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("model", {20'd0, clk_out, rise_pulse, fall_pulse, cfg_pending},
                 {20'd0, m_out, m_rise, m_fall, m_pend});
  endtask

  // Steps until the selected output bit equals 1; n = steps taken, -1 on timeout.
  // sel: 0 = clk_out, 1 = rise_pulse, 2 = fall_pulse.
  task automatic run_until(input int ch, input int sel, input int max, output int n);
    logic hit;
    n = -1;
    for (int k = 1; k <= max; k++) begin
      step();
      hit = (sel == 0) ? clk_out[ch] : (sel == 1) ? rise_pulse[ch] : fall_pulse[ch];
      if (hit) begin
        n = k;
        break;
      end
    end
    if (n < 0) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic drive(input logic r, input logic [NCH-1:0] e, input logic s,
                       input logic w, input logic [1:0] c, input logic [7:0] h,
                       input logic [7:0] l);
    reset = r; en = e; sync = s; cfg_wr = w; cfg_ch = c; cfg_high = h; cfg_low = l;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync;
    logic           wr;
    logic [1:0]     ch;
    logic [7:0]     hi;
    logic [7:0]     lo;
    logic [NCH-1:0] e_out;
    logic [NCH-1:0] e_rise;
    logic [NCH-1:0] e_fall;
    logic [NCH-1:0] e_pend;
  } vec_t;

  vec_t vecs[19];

  initial begin
    int n;
    int r0;
    int r1;

    drive(1'b0, '0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);

    // Defaults 3/3 from reset, then ch0 programmed to 0/0 (stored as 1/1),
    // plus a write to nonexistent channel 3 that must be ignored.
    vecs[0]  = '{1'b0, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[1]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[3]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b111, 3'b000, 3'b000};
    vecs[4]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b000, 3'b000, 3'b000};
    vecs[5]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b000, 3'b000, 3'b000};
    vecs[6]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b111, 3'b000};
    vecs[7]  = '{1'b1, 3'b111, 1'b0, 1'b1, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000, 3'b001};
    vecs[8]  = '{1'b1, 3'b111, 1'b0, 1'b1, 2'd3, 8'd9, 8'd9, 3'b000, 3'b000, 3'b000, 3'b001};
    vecs[9]  = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b111, 3'b000, 3'b001};
    vecs[10] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b000, 3'b000, 3'b001};
    vecs[11] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b000, 3'b000, 3'b001};
    vecs[12] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b111, 3'b000};
    vecs[13] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b001, 3'b001, 3'b000, 3'b000};
    vecs[14] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b001, 3'b000};
    vecs[15] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b111, 3'b000, 3'b000};
    vecs[16] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b110, 3'b000, 3'b001, 3'b000};
    vecs[17] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 3'b001, 3'b000, 3'b000};
    vecs[18] = '{1'b1, 3'b111, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b111, 3'b000};

    @(negedge clk);
    for (int v = 0; v < 19; v++) begin
      drive(vecs[v].rst_n, vecs[v].en, vecs[v].sync, vecs[v].wr,
            vecs[v].ch, vecs[v].hi, vecs[v].lo);
      step();
      chk("vector", {20'd0, clk_out, rise_pulse, fall_pulse, cfg_pending},
                    {20'd0, vecs[v].e_out, vecs[v].e_rise, vecs[v].e_fall, vecs[v].e_pend});
    end
    cfg_wr = 1'b0;

    // ch1 reprogrammed to 2 high / 5 low while in its high phase.
    run_until(1, 0, 10, n);
    drive(1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 8'd2, 8'd5);
    step();
    cfg_wr = 1'b0;
    chk("ch1_pending_set", {31'd0, cfg_pending[1]}, 32'd1);
    run_until(1, 2, 10, n);
    chk("ch1_pending_clr", {31'd0, cfg_pending[1]}, 32'd0);
    run_until(1, 1, 20, n);
    chk("ch1_new_low_len", n, 5);
    run_until(1, 2, 20, n);
    chk("ch1_new_high_len", n, 2);

    // ch0 6/6 and ch1 3/3, then a sync pulse aligns both.
    drive(1'b1, 3'b111, 1'b0, 1'b1, 2'd0, 8'd6, 8'd6);
    step();
    drive(1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 8'd3, 8'd3);
    step();
    cfg_wr = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("pending_drained", {29'd0, cfg_pending}, 32'd0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_out_low", {30'd0, clk_out[1:0]}, 32'd0);
    r0 = -1;
    r1 = -1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (rise_pulse[0] && r0 < 0) r0 = k;
      if (rise_pulse[1] && r1 < 0) r1 = k;
    end
    chk("sync_rise_ch1", r1, 3);
    chk("sync_rise_ch0", r0, 6);

    // en[0] dropped mid-high: no fall pulse, output forced low.
    run_until(0, 0, 15, n);
    step();
    en = 3'b110;
    step();
    chk("dis_out0", {31'd0, clk_out[0]}, 32'd0);
    chk("dis_fall0", {31'd0, fall_pulse[0]}, 32'd0);
    step();
    step();
    en = 3'b111;
    run_until(0, 1, 15, n);
    chk("reen_rise_ch0", n, 6);

    // One-cycle reset mid-high with a write pending on ch1.
    run_until(1, 0, 10, n);
    drive(1'b1, 3'b111, 1'b0, 1'b1, 2'd1, 8'd4, 8'd4);
    step();
    cfg_wr = 1'b0;
    chk("rst_pend_before", {31'd0, cfg_pending[1]}, 32'd1);
    reset = 1'b0;
    step();
    chk("rst_outputs", {20'd0, clk_out, rise_pulse, fall_pulse, cfg_pending}, 32'd0);
    reset = 1'b1;
    run_until(1, 1, 10, n);
    chk("rst_restart_low", n, 3);
    run_until(1, 2, 10, n);
    chk("rst_restart_high", n, 3);

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      reset = ($urandom_range(0, 199) != 0);
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(0, 9) != 0);
      sync     = ($urandom_range(0, 39) == 0);
      cfg_wr   = ($urandom_range(0, 3) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_high = 8'($urandom_range(0, 5));
      cfg_low  = 8'($urandom_range(0, 5));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
